// File: rtl/node_fifo_validready.sv
// node_fifo_validready: DEPTH-entry first-word-fall-through buffer between valid/ready streams,
// with registered ready/valid/almost_full, occupancy count and synchronous flush.
module node_fifo_validready #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_up_in,
    output logic             ready_up_out,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_down_out,
    input  logic             ready_down_in,
    output logic [CW-1:0]    count,
    output logic             almost_full
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             up_fire, down_fire;
    logic [CW-1:0]    next_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign up_fire    = valid_up_in & ready_up_out;
    assign down_fire  = valid_down_out & ready_down_in;
    assign next_count = flush ? '0 : count + CW'(up_fire) - CW'(down_fire);
    assign data_out   = mem[rd_ptr];

    // All status outputs are registered from next_count, so nothing downstream-facing
    // depends combinationally on the current cycle's handshake inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            ready_up_out   <= 1'b0;
            valid_down_out <= 1'b0;
            almost_full    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            count          <= next_count;
            ready_up_out   <= next_count < CW'(DEPTH);
            valid_down_out <= next_count != '0;
            almost_full    <= next_count >= CW'(AF_LEVEL);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (up_fire) begin
                    mem[wr_ptr] <= data_in;
                    wr_ptr      <= ptr_inc(wr_ptr);
                end
                if (down_fire) rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end
endmodule

// File: tb/tb_node_fifo_validready.sv
// tb_node_fifo_validready: directed vector table, streaming run and randomised scoreboard run
// for node_fifo_validready at WIDTH=8, DEPTH=4, AF_LEVEL=3.
module tb_node_fifo_validready;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] data_in = '0;
    logic       valid_up_in = 1'b0;
    logic       ready_up_out;
    logic [7:0] data_out;
    logic       valid_down_out;
    logic       ready_down_in = 1'b0;
    logic [2:0] count;
    logic       almost_full;

    int nvec = 0;
    int nerr = 0;

    node_fifo_validready #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in),
        .valid_up_in(valid_up_in), .ready_up_out(ready_up_out),
        .data_out(data_out), .valid_down_out(valid_down_out),
        .ready_down_in(ready_down_in), .count(count), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       f, v;
        logic [7:0] d;
        logic       rd;
        logic       e_rdy, e_vd;
        logic [7:0] e_do;
        logic [2:0] e_cnt;
        logic       e_af;
    } vec_t;

    vec_t tbl[24];

    task automatic check(input string name, input int idx, input logic e_rdy, input logic e_vd,
                         input logic [7:0] e_do, input logic [2:0] e_cnt, input logic e_af,
                         input bit chk_data);
        logic [5:0] got, exp;
        got = {ready_up_out, valid_down_out, count, almost_full};
        exp = {e_rdy, e_vd, e_cnt, e_af};
        nvec++;
        if (got !== exp || (chk_data && data_out !== e_do)) begin
            nerr++;
            $display("FAIL %s[%0d]: got rdy=%b vd=%b cnt=%0d af=%b do=%02h, required rdy=%b vd=%b cnt=%0d af=%b do=%02h",
                     name, idx, ready_up_out, valid_down_out, count, almost_full, data_out,
                     e_rdy, e_vd, e_cnt, e_af, e_do);
        end
    endtask

    task automatic drive(input logic f, input logic v, input logic [7:0] d, input logic rd);
        @(negedge clk);
        flush = f; valid_up_in = v; data_in = d; ready_down_in = rd;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic       m_rdy;
    int         pushed;
    int         cyc;

    initial begin
        //          f  v  d      rd rdy vd do     cnt af
        tbl[0]  = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 3'd0, 0};
        tbl[1]  = '{0, 1, 8'h11, 0, 1, 1, 8'h11, 3'd1, 0};
        tbl[2]  = '{0, 1, 8'h22, 0, 1, 1, 8'h11, 3'd2, 0};
        tbl[3]  = '{0, 1, 8'h33, 0, 1, 1, 8'h11, 3'd3, 1};
        tbl[4]  = '{0, 1, 8'h44, 0, 0, 1, 8'h11, 3'd4, 1};
        tbl[5]  = '{0, 1, 8'h55, 0, 0, 1, 8'h11, 3'd4, 1};
        tbl[6]  = '{0, 1, 8'h55, 0, 0, 1, 8'h11, 3'd4, 1};
        tbl[7]  = '{0, 1, 8'h55, 1, 1, 1, 8'h22, 3'd3, 1};
        tbl[8]  = '{0, 1, 8'h55, 0, 0, 1, 8'h22, 3'd4, 1};
        tbl[9]  = '{0, 0, 8'h00, 1, 1, 1, 8'h33, 3'd3, 1};
        tbl[10] = '{0, 0, 8'h00, 1, 1, 1, 8'h44, 3'd2, 0};
        tbl[11] = '{0, 0, 8'h00, 1, 1, 1, 8'h55, 3'd1, 0};
        tbl[12] = '{0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd0, 0};
        tbl[13] = '{0, 1, 8'hA0, 0, 1, 1, 8'hA0, 3'd1, 0};
        tbl[14] = '{0, 1, 8'hA1, 0, 1, 1, 8'hA0, 3'd2, 0};
        tbl[15] = '{1, 1, 8'hB0, 0, 1, 0, 8'h00, 3'd0, 0};
        tbl[16] = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 3'd0, 0};
        tbl[17] = '{0, 1, 8'hC0, 0, 1, 1, 8'hC0, 3'd1, 0};
        tbl[18] = '{0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd0, 0};
        tbl[19] = '{0, 1, 8'hD0, 0, 1, 1, 8'hD0, 3'd1, 0};
        tbl[20] = '{0, 1, 8'hD1, 0, 1, 1, 8'hD0, 3'd2, 0};
        tbl[21] = '{0, 1, 8'hD2, 0, 1, 1, 8'hD0, 3'd3, 1};
        tbl[22] = '{0, 1, 8'hD3, 0, 0, 1, 8'hD0, 3'd4, 1};
        tbl[23] = '{1, 1, 8'hEE, 1, 1, 0, 8'h00, 3'd0, 0};

        #3;
        check("reset", 0, 0, 0, 8'h00, 3'd0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_pre_edge", 0, 0, 0, 8'h00, 3'd0, 0, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].rd);
            check("table", i, tbl[i].e_rdy, tbl[i].e_vd, tbl[i].e_do, tbl[i].e_cnt, tbl[i].e_af,
                  tbl[i].e_vd);
        end

        // Sustained push+pop: one word per cycle with a single entry resident.
        for (int i = 0; i < 100; i++) begin
            drive(0, 1, 8'(i), 1);
            check("stream", i, 1, 1, 8'(i), 3'd1, 0, 1);
        end
        drive(0, 0, 8'h00, 1);
        check("stream_drain", 0, 1, 0, 8'h00, 3'd0, 0, 0);

        q.delete();
        m_rdy  = 1'b1;
        pushed = 0;
        cyc    = 0;
        while (pushed < 10000 && cyc < 40000) begin
            logic v, rd, up, dn;
            logic [7:0] d;
            v  = ($urandom_range(0, 9) < 7);
            rd = ($urandom_range(0, 9) < 6);
            d  = 8'($urandom);
            up = v & m_rdy;
            dn = rd & (q.size() != 0);
            drive(0, v, d, rd);
            if (dn) void'(q.pop_front());
            if (up) begin
                q.push_back(d);
                pushed++;
            end
            m_rdy = q.size() < 4;
            check("random", cyc, m_rdy, q.size() != 0, (q.size() != 0) ? q[0] : 8'h00,
                  3'(q.size()), q.size() >= 3, q.size() != 0);
            cyc++;
            if (pushed == 5000 && up) begin
                #1 rst_n = 1'b0;
                #1 check("midreset", cyc, 0, 0, 8'h00, 3'd0, 0, 1);
                #1 rst_n = 1'b1;
                #1 check("midreset_release", cyc, 0, 0, 8'h00, 3'd0, 0, 1);
                q.delete();
                m_rdy = 1'b0;
            end
        end
        nvec++;
        if (pushed < 10000) begin
            nerr++;
            $display("FAIL random_budget: got %0d words pushed, required 10000", pushed);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
